// File: rtl/yutorina_bus_master_pkg.sv
// rtl/yutorina_bus_master_pkg.sv - shared encodings for the yutorina bus master
//
// Purpose: FSM state encoding, transfer direction codes, active-low
// enable levels and the default ready timeout used by the bus master.
// Ports: none (package).

package yutorina_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Bus strobes are active-low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/yutorina_bus_master_if.sv
// rtl/yutorina_bus_master_if.sv - yutorina shared bus signal bundle
//
// Purpose: groups the arbiter handshake and the slave access signals.
// Signals:
//   bus_req_    master -> arbiter  bus request, active-low
//   bus_grnt_   arbiter -> master  bus grant, active-low
//   bus_as_     master -> slave    address strobe, active-low
//   bus_rw      master -> slave    1 = read, 0 = write
//   bus_addr    master -> slave    word address
//   bus_wr_data master -> slave    write data
//   bus_rd_data slave -> master    read data
//   bus_rdy_    slave -> master    ready, active-low

interface yutorina_bus_master_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) ();

    logic              bus_req_;
    logic              bus_grnt_;
    logic              bus_as_;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_,
        output bus_as_,
        output bus_rw,
        output bus_addr,
        output bus_wr_data,
        input  bus_grnt_,
        input  bus_rd_data,
        input  bus_rdy_
    );

    modport slave (
        input  bus_req_,
        input  bus_as_,
        input  bus_rw,
        input  bus_addr,
        input  bus_wr_data,
        output bus_grnt_,
        output bus_rd_data,
        output bus_rdy_
    );

endinterface

// File: rtl/yutorina_bus_master.sv
// rtl/yutorina_bus_master.sv - single-transfer initiator on the yutorina bus
//
// Purpose: accepts one read/write request from the CPU side, obtains bus
// ownership from the arbiter, strobes the slave and waits for its ready,
// aborting with an error after TIMEOUT access cycles.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_req_i         transfer request (sampled only when idle)
//   cpu_rw_i          1 = read, 0 = write
//   cpu_addr_i        word address
//   cpu_wr_data_i     write data
//   cpu_rd_data_o     read result, valid with cpu_done_o and held after
//   cpu_busy_o        transfer in progress
//   cpu_done_o        one-cycle completion pulse
//   cpu_err_o         one-cycle timeout pulse, coincident with cpu_done_o
//   bus               yutorina bus, master view

module yutorina_bus_master
    import yutorina_bus_master_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req_i,
    input  logic                     cpu_rw_i,
    input  logic [ADDR_W-1:0]        cpu_addr_i,
    input  logic [DATA_W-1:0]        cpu_wr_data_i,
    output logic [DATA_W-1:0]        cpu_rd_data_o,
    output logic                     cpu_busy_o,
    output logic                     cpu_done_o,
    output logic                     cpu_err_o,
    yutorina_bus_master_if.master    bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              bus_req_q;
    logic              bus_as_q;
    logic              bus_rw_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wr_data_q;
    logic [DATA_W-1:0] cpu_rd_data_q;
    logic              cpu_busy_q;
    logic              cpu_done_q;
    logic              cpu_err_q;
    logic              rdy_ok;
    logic              timeout_hit;

    // Saturating increment: the counter must never wrap back into the
    // "first access cycle" window where ready is ignored.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Ready seen on the first access cycle may be a registered slave still
    // answering the previous transfer, so it only counts from cycle 2 on.
    assign rdy_ok      = (bus.bus_rdy_ == ENABLE_) && (cnt_q >= CNT_TWO);
    assign timeout_hit = (cnt_q == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_rw_q      <= READ;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            cpu_rd_data_q <= '0;
            cpu_busy_q    <= 1'b0;
            cpu_done_q    <= 1'b0;
            cpu_err_q     <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            cpu_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_i) begin
                        state_q       <= ST_REQ;
                        bus_req_q     <= ENABLE_;
                        cpu_busy_q    <= 1'b1;
                        bus_rw_q      <= cpu_rw_i;
                        bus_addr_q    <= cpu_addr_i;
                        bus_wr_data_q <= cpu_wr_data_i;
                    end
                end
                ST_REQ: begin
                    // No timeout while waiting for the arbiter.
                    if (bus.bus_grnt_ == ENABLE_) begin
                        state_q  <= ST_ACCESS;
                        bus_as_q <= ENABLE_;
                        cnt_q    <= CNT_ONE;
                    end
                end
                ST_ACCESS: begin
                    if (rdy_ok) begin
                        state_q    <= ST_IDLE;
                        bus_as_q   <= DISABLE_;
                        bus_req_q  <= DISABLE_;
                        cpu_busy_q <= 1'b0;
                        cpu_done_q <= 1'b1;
                        cnt_q      <= '0;
                        if (bus_rw_q != WRITE) begin
                            cpu_rd_data_q <= bus.bus_rd_data;
                        end
                    end else if (timeout_hit) begin
                        state_q       <= ST_IDLE;
                        bus_as_q      <= DISABLE_;
                        bus_req_q     <= DISABLE_;
                        cpu_busy_q    <= 1'b0;
                        cpu_done_q    <= 1'b1;
                        cpu_err_q     <= 1'b1;
                        cpu_rd_data_q <= '0;
                        cnt_q         <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bus_req_    = bus_req_q;
    assign bus.bus_as_     = bus_as_q;
    assign bus.bus_rw      = bus_rw_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wr_data = bus_wr_data_q;

    assign cpu_rd_data_o = cpu_rd_data_q;
    assign cpu_busy_o    = cpu_busy_q;
    assign cpu_done_o    = cpu_done_q;
    assign cpu_err_o     = cpu_err_q;

endmodule

// File: tb/tb_yutorina_bus_master.sv
// tb/tb_yutorina_bus_master.sv - self-checking bench for yutorina_bus_master

module tb_yutorina_bus_master;

    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic [DATA_W-1:0] cpu_rd_data;
    logic              cpu_busy;
    logic              cpu_done;
    logic              cpu_err;

    int                checks;
    int                failures;
    logic [DATA_W-1:0] last_rd;

    yutorina_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    yutorina_bus_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_i     (cpu_req),
        .cpu_rw_i      (cpu_rw),
        .cpu_addr_i    (cpu_addr),
        .cpu_wr_data_i (cpu_wr_data),
        .cpu_rd_data_o (cpu_rd_data),
        .cpu_busy_o    (cpu_busy),
        .cpu_done_o    (cpu_done),
        .cpu_err_o     (cpu_err),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_"},  32'(bus.bus_req_), 32'd1);
        check({tag, "_as_"},   32'(bus.bus_as_), 32'd1);
        check({tag, "_rw"},    32'(bus.bus_rw), 32'd1);
        check({tag, "_addr"},  32'(bus.bus_addr), 32'd0);
        check({tag, "_wdata"}, bus.bus_wr_data, 32'd0);
        check({tag, "_rdata"}, cpu_rd_data, 32'd0);
        check({tag, "_busy"},  32'(cpu_busy), 32'd0);
        check({tag, "_done"},  32'(cpu_done), 32'd0);
        check({tag, "_err"},   32'(cpu_err), 32'd0);
    endtask

    // One transfer. Cycle 0 is the cycle whose closing edge samples cpu_req.
    // g: cycles the grant is withheld after the request appears.
    // l: slave answers once it has seen more than l strobe cycles
    //    (l = 0 models a stale ready held low from before the access).
    // Expected timing from the protocol: access cycle a starts at cycle
    // 2+g, ready counts from a = 2, completion is reported the cycle after
    // the accepting access cycle, or after access cycle TIMEOUT.
    task automatic do_txn(input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                          input int g, input int l);
        int                a_done;
        int                done_c;
        int                as_cnt;
        logic              exp_err;
        logic              rdy_low;
        logic [DATA_W-1:0] exp_rd;
        a_done  = (l < 1) ? 2 : l + 1;
        exp_err = (a_done > TIMEOUT);
        if (exp_err) a_done = TIMEOUT;
        done_c  = 2 + g + a_done;
        exp_rd  = exp_err ? '0 : ((rw == 1'b1) ? rd : last_rd);
        as_cnt  = 0;

        cpu_req         = 1'b1;
        cpu_rw          = rw;
        cpu_addr        = addr;
        cpu_wr_data     = wd;
        bus.bus_grnt_   = 1'($urandom_range(0, 1));
        bus.bus_rdy_    = (l == 0) ? 1'b0 : 1'b1;
        bus.bus_rd_data = (l == 0) ? rd : $urandom;

        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk);
            #1;
            if (bus.bus_as_ == 1'b0) as_cnt++;
            check("done",  32'(cpu_done), 32'(c == done_c));
            check("err",   32'(cpu_err), 32'(c == done_c && exp_err));
            check("busy",  32'(cpu_busy), 32'(c < done_c));
            check("req_",  32'(bus.bus_req_), 32'(!(c < done_c)));
            check("as_",   32'(bus.bus_as_), 32'(!(c >= 2 + g && c < done_c)));
            check("rw",    32'(bus.bus_rw), 32'(rw));
            check("addr",  32'(bus.bus_addr), 32'(addr));
            check("wdata", bus.bus_wr_data, wd);
            check("rdata", cpu_rd_data, (c == done_c) ? exp_rd : last_rd);

            // Stimulus for the remainder of cycle c.
            if (c < done_c) begin
                cpu_req     = 1'($urandom_range(0, 1));
                cpu_rw      = 1'($urandom_range(0, 1));
                cpu_addr    = ADDR_W'($urandom);
                cpu_wr_data = $urandom;
            end else begin
                cpu_req = 1'b0;
            end
            if (c < 1 + g)       bus.bus_grnt_ = 1'b1;
            else if (c == 1 + g) bus.bus_grnt_ = 1'b0;
            else                 bus.bus_grnt_ = 1'($urandom_range(0, 1));
            rdy_low         = (c < done_c) && (l == 0 || as_cnt > l);
            bus.bus_rdy_    = !rdy_low;
            bus.bus_rd_data = rdy_low ? rd : $urandom;
        end
        last_rd = exp_rd;
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.bus_grnt_ = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("idle_done",  32'(cpu_done), 32'd0);
            check("idle_busy",  32'(cpu_busy), 32'd0);
            check("idle_as_",   32'(bus.bus_as_), 32'd1);
            check("idle_req_",  32'(bus.bus_req_), 32'd1);
            check("idle_rdata", cpu_rd_data, last_rd);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        last_rd         = '0;
        rst             = 1'b1;
        cpu_req         = 1'b0;
        cpu_rw          = 1'b0;
        cpu_addr        = '0;
        cpu_wr_data     = '0;
        bus.bus_grnt_   = 1'b1;
        bus.bus_rdy_    = 1'b1;
        bus.bus_rd_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        idle(1);

        // Directed scenarios.
        do_txn(1'b1, 30'h10, 32'h0, 32'h12345678, 0, 1);
        idle(1);
        do_txn(1'b0, 30'h3FFFFFF, 32'hDEADBEEF, 32'hA5A5A5A5, 0, 3);
        do_txn(1'b1, 30'h123, 32'h0, 32'hCAFEF00D, 5, 1);
        do_txn(1'b1, 30'h55, 32'h0, 32'h11111111, 1, 1000);
        do_txn(1'b1, 30'h77, 32'h0, 32'h0BADF00D, 0, 0);
        do_txn(1'b0, 30'h78, 32'h01020304, 32'h0, 2, 0);

        // Reset in the middle of an access, with cpu_req held high.
        cpu_req       = 1'b1;
        cpu_rw        = 1'b1;
        cpu_addr      = 30'h2AA;
        bus.bus_grnt_ = 1'b0;
        bus.bus_rdy_  = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("abort_as_",  32'(bus.bus_as_), 32'd0);
        check("abort_busy", 32'(cpu_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("abort");
        rst     = 1'b0;
        last_rd = '0;
        do_txn(1'b1, 30'h2AB, 32'h0, 32'h87654321, 0, 1);

        // Randomized transfers.
        for (int n = 0; n < 40; n++) begin
            int g;
            int l;
            g = $urandom_range(0, 3);
            l = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 5);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            do_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, $urandom, g, l);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
